// File: rtl/c1541_disk_sequencer.sv
// c1541_disk_sequencer
// Drive-mechanics sequencer for the 1541 core. Sits between the drive-side pins of
// c1541_logic and a track buffer RAM:
//   - decodes the stepper phases into a half-track head position
//   - asks the host to save/load tracks through a track_req/track_ack handshake
//   - paces GCR bytes out of the buffer at the zone bit rate (byte_n, sync_n)
//   - writes the bytes coming back from the logic into the buffer in write mode
// Ports:
//   clk32, reset                 32 MHz clock, asynchronous active-high reset
//   mtr, freq, stp, mode         motor, density zone, stepper phase, 1=read/0=write
//   disk_dout / disk_din         byte from / to the drive logic
//   byte_n, sync_n               byte-ready and sync strobes, active low
//   wps_n, tr00_sense_n          write-protect and track-0 sense
//   img_mounted, img_readonly    image presence and write protection
//   track_len                    byte count of the loaded track (0 = unformatted)
//   half_track                   current head position
//   track_req, track_ack, dirty  host load handshake and buffer-modified flag
//   buf_addr/rdata/wdata/we      track buffer port (1-cycle read latency)
module c1541_disk_sequencer #(
  parameter int unsigned HTRACK_MAX  = 83,
  parameter int unsigned HTRACK_INIT = 34,
  parameter int unsigned BYTE_PULSE  = 64,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              mtr,
  input  logic [1:0]        freq,
  input  logic [1:0]        stp,
  input  logic              mode,
  input  logic [7:0]        disk_dout,
  output logic [7:0]        disk_din,
  output logic              byte_n,
  output logic              sync_n,
  output logic              wps_n,
  output logic              tr00_sense_n,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [ADDR_W-1:0] track_len,
  output logic [6:0]        half_track,
  output logic              track_req,
  input  logic              track_ack,
  output logic              dirty,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        buf_wdata,
  output logic              buf_we
);

  localparam int unsigned PW = $clog2(BYTE_PULSE + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;

  state_t            state;
  logic [1:0]        stp_q;
  logic              primed;
  logic              step_up;
  logic              step_dn;
  logic [6:0]        half_track_d;
  logic              ht_change;
  logic [9:0]        timer;
  logic [9:0]        period_m1;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] pos_next;
  logic [PW-1:0]     pulse_cnt;
  logic [7:0]        prev;
  logic              run_ok;
  logic              boundary;

  // Stepper decode: a +1 phase rotation moves the head inward, -1 outward,
  // a jump of two phases is ambiguous and ignored.
  always_comb begin
    step_up      = primed && (stp == stp_q + 2'd1);
    step_dn      = primed && (stp == stp_q - 2'd1);
    half_track_d = half_track;
    if (step_up && (half_track < 7'(HTRACK_MAX))) begin
      half_track_d = half_track + 7'd1;
    end else if (step_dn && (half_track != 7'd0)) begin
      half_track_d = half_track - 7'd1;
    end
  end

  assign ht_change = (half_track_d != half_track);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      stp_q      <= 2'd0;
      primed     <= 1'b0;
      half_track <= 7'(HTRACK_INIT);
    end else begin
      primed     <= 1'b1;
      stp_q      <= stp;
      half_track <= half_track_d;
    end
  end

  assign wps_n        = ~(img_mounted & img_readonly);
  assign tr00_sense_n = (half_track != 7'd0);

  // Byte period minus one: (16 - freq) * 64 - 1 = {15 - freq, 6'h3f}.
  assign period_m1 = {2'b11, ~freq, 6'h3f};

  // The byte engine only advances in RUN with the motor spinning on a formatted
  // track, and not in a cycle that is about to leave RUN.
  assign run_ok   = (state == StRun) && img_mounted && !ht_change && mtr &&
                    (track_len != '0);
  assign boundary = run_ok && (timer == '0);
  assign pos_next = (pos >= track_len - ADDR_W'(1)) ? '0 : pos + ADDR_W'(1);

  assign buf_addr  = pos;
  assign buf_wdata = disk_dout;
  assign buf_we    = boundary && !mode && !img_readonly;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      track_req <= 1'b0;
      dirty     <= 1'b0;
      pos       <= '0;
      timer     <= '0;
      pulse_cnt <= '0;
      byte_n    <= 1'b1;
      sync_n    <= 1'b1;
      disk_din  <= 8'h00;
      prev      <= 8'h00;
    end else begin
      // Finish any byte_n pulse in flight; a boundary below may restart it.
      if (!byte_n) begin
        if (pulse_cnt == '0) begin
          byte_n <= 1'b1;
        end else begin
          pulse_cnt <= pulse_cnt - PW'(1);
        end
      end
      if (!run_ok) begin
        byte_n <= 1'b1;
        sync_n <= 1'b1;
      end

      case (state)
        StIdle: begin
          if (img_mounted) begin
            state     <= StLoad;
            track_req <= 1'b1;
          end
        end
        StLoad: begin
          // Steps during LOAD keep the request up; the host reads half_track at ack.
          if (!img_mounted) begin
            state     <= StIdle;
            track_req <= 1'b0;
          end else if (track_ack) begin
            state     <= StRun;
            track_req <= 1'b0;
            dirty     <= 1'b0;
            pos       <= '0;
            timer     <= period_m1;
          end
        end
        StRun: begin
          if (!img_mounted) begin
            state     <= StIdle;
            track_req <= 1'b0;
          end else if (ht_change) begin
            state     <= StLoad;
            track_req <= 1'b1;
          end else if (run_ok) begin
            if (!boundary) begin
              timer <= timer - 10'd1;
            end else begin
              // freq is only sampled here, so zone changes apply from the next byte.
              timer <= period_m1;
              pos   <= pos_next;
              if (mode) begin
                disk_din <= buf_rdata;
                prev     <= buf_rdata;
                if ((buf_rdata == 8'hff) && (prev == 8'hff)) begin
                  // Sync bytes are never reported through byte_n.
                  sync_n <= 1'b0;
                  byte_n <= 1'b1;
                end else begin
                  sync_n    <= 1'b1;
                  byte_n    <= 1'b0;
                  pulse_cnt <= PW'(BYTE_PULSE - 1);
                end
              end else begin
                sync_n    <= 1'b1;
                byte_n    <= 1'b0;
                pulse_cnt <= PW'(BYTE_PULSE - 1);
                if (!img_readonly) begin
                  dirty <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state     <= StIdle;
          track_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_disk_sequencer.sv
`timescale 1ns/1ps
module tb_c1541_disk_sequencer;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        mtr = 1'b0;
  logic [1:0]  freq = 2'd0;
  logic [1:0]  stp = 2'd0;
  logic        mode = 1'b1;
  logic [7:0]  disk_dout = 8'h00;
  logic [7:0]  disk_din;
  logic        byte_n;
  logic        sync_n;
  logic        wps_n;
  logic        tr00_sense_n;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [12:0] track_len = 13'd0;
  logic [6:0]  half_track;
  logic        track_req;
  logic        track_ack = 1'b0;
  logic        dirty;
  logic [12:0] buf_addr;
  logic [7:0]  buf_rdata = 8'h00;
  logic [7:0]  buf_wdata;
  logic        buf_we;

  logic [7:0]  mem [0:15];
  int          wr_count = 0;
  logic [12:0] wr_addr_last = 13'd0;
  logic [7:0]  wr_data_last = 8'h00;
  int          checks = 0;
  int          fails = 0;

  c1541_disk_sequencer dut (
    .clk32(clk32), .reset(reset), .mtr(mtr), .freq(freq), .stp(stp), .mode(mode),
    .disk_dout(disk_dout), .disk_din(disk_din), .byte_n(byte_n), .sync_n(sync_n),
    .wps_n(wps_n), .tr00_sense_n(tr00_sense_n), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .track_len(track_len), .half_track(half_track),
    .track_req(track_req), .track_ack(track_ack), .dirty(dirty), .buf_addr(buf_addr),
    .buf_rdata(buf_rdata), .buf_wdata(buf_wdata), .buf_we(buf_we)
  );

  always #5 clk32 = ~clk32;

  // Track buffer model: registered read, writes only logged.
  always @(posedge clk32) begin
    buf_rdata <= mem[buf_addr[3:0]];
    if (buf_we) begin
      wr_count     <= wr_count + 1;
      wr_addr_last <= buf_addr;
      wr_data_last <= buf_wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (half_track !== 7'd34) begin fails++; $display("FAIL reset_half_track got %0d want 34", half_track); end
    checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL reset_byte_n got %b want 1", byte_n); end
    checks++; if (sync_n !== 1'b1) begin fails++; $display("FAIL reset_sync_n got %b want 1", sync_n); end
    checks++; if (disk_din !== 8'h00) begin fails++; $display("FAIL reset_disk_din got %h want 00", disk_din); end
    checks++; if (track_req !== 1'b0) begin fails++; $display("FAIL reset_track_req got %b want 0", track_req); end
    checks++; if (dirty !== 1'b0) begin fails++; $display("FAIL reset_dirty got %b want 0", dirty); end
    checks++; if (buf_we !== 1'b0) begin fails++; $display("FAIL reset_buf_we got %b want 0", buf_we); end
    checks++; if (buf_addr !== 13'd0) begin fails++; $display("FAIL reset_buf_addr got %0d want 0", buf_addr); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_mount;
    img_mounted = 1'b1;
    tick(1);
    checks++; if (track_req !== 1'b1) begin fails++; $display("FAIL mount_track_req got %b want 1", track_req); end
    checks++; if (half_track !== 7'd34) begin fails++; $display("FAIL mount_half_track got %0d want 34", half_track); end
    track_ack = 1'b1;
    tick(1);
    track_ack = 1'b0;
    checks++; if (track_req !== 1'b0) begin fails++; $display("FAIL ack_track_req got %b want 0", track_req); end
    checks++; if (dirty !== 1'b0) begin fails++; $display("FAIL ack_dirty got %b want 0", dirty); end
    checks++; if (tr00_sense_n !== 1'b1) begin fails++; $display("FAIL ack_tr00 got %b want 1", tr00_sense_n); end
    checks++; if (wps_n !== 1'b1) begin fails++; $display("FAIL ack_wps_n got %b want 1", wps_n); end
  endtask

  task automatic test_step;
    logic [1:0] st;
    st = 2'd0;
    for (int i = 0; i < 4; i++) begin
      st = st + 2'd1;
      stp = st;
      tick(1);
      checks++; if (half_track !== 7'(35 + i)) begin fails++; $display("FAIL step_up%0d got %0d want %0d", i, half_track, 35 + i); end
      checks++; if (track_req !== 1'b1) begin fails++; $display("FAIL step_req%0d got %b want 1", i, track_req); end
    end
    st = 2'd2;
    stp = st;
    tick(1);
    checks++; if (half_track !== 7'd38) begin fails++; $display("FAIL step_diff2 got %0d want 38", half_track); end
    for (int i = 0; i < 50; i++) begin
      st = st + 2'd1;
      stp = st;
      tick(1);
    end
    checks++; if (half_track !== 7'd83) begin fails++; $display("FAIL step_clamp_max got %0d want 83", half_track); end
    for (int i = 0; i < 90; i++) begin
      st = st - 2'd1;
      stp = st;
      tick(1);
    end
    checks++; if (half_track !== 7'd0) begin fails++; $display("FAIL step_clamp_zero got %0d want 0", half_track); end
    checks++; if (tr00_sense_n !== 1'b0) begin fails++; $display("FAIL step_tr00 got %b want 0", tr00_sense_n); end
    checks++; if (track_req !== 1'b1) begin fails++; $display("FAIL step_req_held got %b want 1", track_req); end
  endtask

  task automatic test_read_stream;
    for (int i = 0; i < 10; i++) mem[i] = 8'(8'h52 + i);
    track_len = 13'd10;
    freq = 2'd3;
    mtr = 1'b1;
    mode = 1'b1;
    track_ack = 1'b1;
    tick(1);
    track_ack = 1'b0;
    checks++; if (track_req !== 1'b0) begin fails++; $display("FAIL read_ack_req got %b want 0", track_req); end
    for (int i = 0; i < 11; i++) begin
      tick(i == 0 ? 831 : 767);
      checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL read_pre%0d byte_n got %b want 1", i, byte_n); end
      tick(1);
      checks++; if (byte_n !== 1'b0) begin fails++; $display("FAIL read_fall%0d byte_n got %b want 0", i, byte_n); end
      checks++; if (disk_din !== 8'(8'h52 + (i % 10))) begin fails++; $display("FAIL read_din%0d got %h want %h", i, disk_din, 8'(8'h52 + (i % 10))); end
      checks++; if (buf_addr !== 13'((i + 1) % 10)) begin fails++; $display("FAIL read_addr%0d got %0d want %0d", i, buf_addr, (i + 1) % 10); end
      checks++; if (sync_n !== 1'b1) begin fails++; $display("FAIL read_sync%0d got %b want 1", i, sync_n); end
      tick(63);
      checks++; if (byte_n !== 1'b0) begin fails++; $display("FAIL read_low64_%0d byte_n got %b want 0", i, byte_n); end
      tick(1);
      checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL read_rise%0d byte_n got %b want 1", i, byte_n); end
    end
  endtask

  task automatic test_sync;
    logic [7:0] din_exp [0:3];
    logic [3:0] sync_exp;
    logic [3:0] byte_exp;
    din_exp[0] = 8'hff; din_exp[1] = 8'hff; din_exp[2] = 8'hff; din_exp[3] = 8'h52;
    sync_exp = 4'b1001;   // bit i = expected sync_n for byte i
    byte_exp = 4'b0110;   // bit i = expected byte_n just after boundary i
    img_mounted = 1'b0;
    tick(1);
    checks++; if (track_req !== 1'b0) begin fails++; $display("FAIL unmount_req got %b want 0", track_req); end
    for (int i = 0; i < 4; i++) mem[i] = din_exp[i];
    track_len = 13'd4;
    img_mounted = 1'b1;
    tick(1);
    checks++; if (track_req !== 1'b1) begin fails++; $display("FAIL remount_req got %b want 1", track_req); end
    track_ack = 1'b1;
    tick(1);
    track_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(i == 0 ? 832 : 802);
      checks++; if (disk_din !== din_exp[i]) begin fails++; $display("FAIL sync_din%0d got %h want %h", i, disk_din, din_exp[i]); end
      checks++; if (sync_n !== sync_exp[i]) begin fails++; $display("FAIL sync_n%0d got %b want %b", i, sync_n, sync_exp[i]); end
      checks++; if (byte_n !== byte_exp[i]) begin fails++; $display("FAIL sync_byte_n%0d got %b want %b", i, byte_n, byte_exp[i]); end
      tick(30);
      checks++; if (byte_n !== byte_exp[i]) begin fails++; $display("FAIL sync_byte_n_late%0d got %b want %b", i, byte_n, byte_exp[i]); end
    end
  endtask

  task automatic test_write;
    int base;
    base = wr_count;
    mode = 1'b0;
    disk_dout = 8'h55;
    for (int k = 0; k < 3; k++) begin
      tick(801);
      checks++; if (buf_we !== 1'b1) begin fails++; $display("FAIL write_we%0d got %b want 1", k, buf_we); end
      checks++; if (buf_addr !== 13'(k)) begin fails++; $display("FAIL write_addr%0d got %0d want %0d", k, buf_addr, k); end
      tick(1);
      checks++; if (wr_count !== base + k + 1) begin fails++; $display("FAIL write_count%0d got %0d want %0d", k, wr_count, base + k + 1); end
      checks++; if (wr_data_last !== 8'h55) begin fails++; $display("FAIL write_data%0d got %h want 55", k, wr_data_last); end
      checks++; if (wr_addr_last !== 13'(k)) begin fails++; $display("FAIL write_log_addr%0d got %0d want %0d", k, wr_addr_last, k); end
      checks++; if (dirty !== 1'b1) begin fails++; $display("FAIL write_dirty%0d got %b want 1", k, dirty); end
      checks++; if (byte_n !== 1'b0) begin fails++; $display("FAIL write_byte_n%0d got %b want 0", k, byte_n); end
      checks++; if (sync_n !== 1'b1) begin fails++; $display("FAIL write_sync_n%0d got %b want 1", k, sync_n); end
      tick(30);
    end
    img_readonly = 1'b1;
    #1;
    checks++; if (wps_n !== 1'b0) begin fails++; $display("FAIL ro_wps_n got %b want 0", wps_n); end
    tick(801);
    checks++; if (buf_we !== 1'b0) begin fails++; $display("FAIL ro_we got %b want 0", buf_we); end
    tick(1);
    checks++; if (wr_count !== base + 3) begin fails++; $display("FAIL ro_count got %0d want %0d", wr_count, base + 3); end
    checks++; if (byte_n !== 1'b0) begin fails++; $display("FAIL ro_byte_n got %b want 0", byte_n); end
    tick(30);
  endtask

  task automatic test_motor;
    int lows;
    int moves;
    mode = 1'b1;
    img_readonly = 1'b0;
    mem[1] = 8'h33;
    mtr = 1'b0;
    tick(1);
    checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL motor_off_byte_n got %b want 1", byte_n); end
    lows = 0;
    moves = 0;
    for (int i = 0; i < 1500; i++) begin
      tick(1);
      if (byte_n !== 1'b1) lows++;
      if (buf_addr !== 13'd0) moves++;
    end
    checks++; if (lows !== 0) begin fails++; $display("FAIL motor_off_pulses got %0d want 0", lows); end
    checks++; if (moves !== 0) begin fails++; $display("FAIL motor_off_pos_moves got %0d want 0", moves); end
    mtr = 1'b1;
    freq = 2'd0;
    tick(801);
    checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL motor_resume_pre got %b want 1", byte_n); end
    tick(1);
    checks++; if (byte_n !== 1'b0) begin fails++; $display("FAIL motor_resume_fall got %b want 0", byte_n); end
    checks++; if (disk_din !== 8'hff) begin fails++; $display("FAIL motor_resume_din got %h want ff", disk_din); end
    tick(832);
    checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL zone_no_832 got %b want 1", byte_n); end
    tick(191);
    checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL zone_pre_1024 got %b want 1", byte_n); end
    tick(1);
    checks++; if (byte_n !== 1'b0) begin fails++; $display("FAIL zone_fall_1024 got %b want 0", byte_n); end
    checks++; if (disk_din !== 8'h33) begin fails++; $display("FAIL zone_din got %h want 33", disk_din); end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    #1;
    checks++; if (byte_n !== 1'b1) begin fails++; $display("FAIL rst_mid_byte_n got %b want 1", byte_n); end
    checks++; if (disk_din !== 8'h00) begin fails++; $display("FAIL rst_mid_din got %h want 00", disk_din); end
    checks++; if (dirty !== 1'b0) begin fails++; $display("FAIL rst_mid_dirty got %b want 0", dirty); end
    checks++; if (half_track !== 7'd34) begin fails++; $display("FAIL rst_mid_half_track got %0d want 34", half_track); end
    checks++; if (track_req !== 1'b0) begin fails++; $display("FAIL rst_mid_req got %b want 0", track_req); end
    checks++; if (buf_addr !== 13'd0) begin fails++; $display("FAIL rst_mid_addr got %0d want 0", buf_addr); end
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_mount();
    test_step();
    test_read_stream();
    test_sync();
    test_write();
    test_motor();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
